// File: rtl/bnn_input_loader_if.sv
// Byte-port / array bus between the chip I/O side and the input loader.
//   state      : top FSM state (s_IDLE=0, s_LOAD=1, s_LAYER_1=2, ...)
//   data_in    : byte from the I/O port, qualified by data_valid
//   ready      : loader accepts a byte this cycle
//   pixels     : binary image, pixels[row][col]
//   weights    : first-layer kernel bits, weights[r][c][k]
//   load_done  : full image and kernel captured
//   checksum   : XOR of all bytes accepted in the current load
interface bnn_input_loader_if #(
    parameter int IMG_DIM = 28,
    parameter int BUS_W   = 8
);
    logic [2:0]                       state;
    logic [BUS_W-1:0]                 data_in;
    logic                             data_valid;
    logic                             ready;
    logic [IMG_DIM-1:0][IMG_DIM-1:0]  pixels;
    logic [2:0][2:0][7:0]             weights;
    logic                             load_done;
    logic [7:0]                       checksum;

    modport master (
        output state, data_in, data_valid,
        input  ready, pixels, weights, load_done, checksum
    );

    modport slave (
        input  state, data_in, data_valid,
        output ready, pixels, weights, load_done, checksum
    );
endinterface

// File: rtl/bnn_input_loader.sv
// Byte-serial loader for the binary image and first-layer kernel.
// While the top FSM sits in s_LOAD it accepts 9 kernel bytes followed by
// IMG_DIM*IMG_DIM/8 pixel bytes (LSB first, row-major), then raises
// load_done. Arrays are held after the load for the layer to consume.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : bnn_input_loader_if.slave (state, data_in/data_valid in;
//          ready, pixels, weights, load_done, checksum out)
module bnn_input_loader #(
    parameter int IMG_DIM     = 28,
    parameter int N_WGT_BYTES = 9,
    parameter int BUS_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    bnn_input_loader_if.slave  bus
);
    localparam int NPIX_BYTES = IMG_DIM * IMG_DIM / BUS_W;
    localparam int CNT_W      = $clog2(NPIX_BYTES > N_WGT_BYTES ? NPIX_BYTES : N_WGT_BYTES);
    localparam int RC_W       = $clog2(IMG_DIM);
    localparam logic [2:0] S_LOAD = 3'd1;

    typedef enum logic [1:0] {L_IDLE, L_WEIGHTS, L_PIXELS, L_DONE} lstate_t;

    lstate_t                         st, nxt;
    logic [CNT_W-1:0]                cnt;
    logic [RC_W-1:0]                 row, col;
    logic [1:0]                      wr, wc;
    logic [IMG_DIM-1:0][IMG_DIM-1:0] pix_q;
    logic [2:0][2:0][7:0]            wgt_q;
    logic [7:0]                      csum_q;
    logic                            ready, load_done;
    logic                            in_load, accept;
    logic                            last_w, last_p;

    // Target row/col for each bit of the current byte; entry BUS_W is the
    // start position of the next byte. A byte spans at most one row wrap
    // since BUS_W < IMG_DIM, so a compare-and-subtract replaces a divider.
    logic [RC_W-1:0] bit_row [BUS_W+1];
    logic [RC_W-1:0] bit_col [BUS_W+1];

    assign in_load = (bus.state == S_LOAD);
    assign accept  = ready & bus.data_valid & in_load;
    assign last_w  = (cnt == CNT_W'(N_WGT_BYTES - 1));
    assign last_p  = (cnt == CNT_W'(NPIX_BYTES - 1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= L_IDLE;
        else     st <= nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        nxt = st;
        if (!in_load) begin
            nxt = L_IDLE;               // leaving s_LOAD always wins
        end else begin
            case (st)
                L_IDLE:    nxt = L_WEIGHTS;
                L_WEIGHTS: if (accept && last_w) nxt = L_PIXELS;
                L_PIXELS:  if (accept && last_p) nxt = L_DONE;
                L_DONE:    nxt = L_DONE;
                default:   nxt = L_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs (state decode only) ----------------
    always_comb begin
        ready     = 1'b0;
        load_done = 1'b0;
        case (st)
            L_WEIGHTS, L_PIXELS: ready     = 1'b1;
            L_DONE:              load_done = 1'b1;
            default: ;
        endcase
    end

    // ---------------- bit placement ----------------
    always_comb begin
        bit_row = '{default: '0};
        bit_col = '{default: '0};
        for (int i = 0; i <= BUS_W; i++) begin
            if ({1'b0, col} + (RC_W+1)'(i) >= (RC_W+1)'(IMG_DIM)) begin
                bit_col[i] = RC_W'({1'b0, col} + (RC_W+1)'(i) - (RC_W+1)'(IMG_DIM));
                bit_row[i] = row + 1'b1;
            end else begin
                bit_col[i] = RC_W'({1'b0, col} + (RC_W+1)'(i));
                bit_row[i] = row;
            end
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            row    <= '0;
            col    <= '0;
            wr     <= '0;
            wc     <= '0;
            pix_q  <= '0;
            wgt_q  <= '0;
            csum_q <= '0;
        end else if (!in_load) begin
            // abort / out of load: position state cleared, arrays and checksum held
            cnt <= '0;
            row <= '0;
            col <= '0;
            wr  <= '0;
            wc  <= '0;
        end else if (st == L_IDLE) begin
            cnt    <= '0;
            row    <= '0;
            col    <= '0;
            wr     <= '0;
            wc     <= '0;
            csum_q <= '0;
        end else if (accept) begin
            csum_q <= csum_q ^ bus.data_in;
            if (st == L_WEIGHTS) begin
                wgt_q[wr][wc] <= bus.data_in;
                if (last_w) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                if (wc == 2'd2) begin
                    wc <= '0;
                    wr <= wr + 1'b1;
                end else begin
                    wc <= wc + 1'b1;
                end
            end else begin
                for (int i = 0; i < BUS_W; i++)
                    pix_q[bit_row[i]][bit_col[i]] <= bus.data_in[i];
                cnt <= cnt + 1'b1;
                row <= bit_row[BUS_W];
                col <= bit_col[BUS_W];
            end
        end
    end

    assign bus.ready     = ready;
    assign bus.load_done = load_done;
    assign bus.pixels    = pix_q;
    assign bus.weights   = wgt_q;
    assign bus.checksum  = csum_q;
endmodule

// File: tb/tb_bnn_input_loader.sv
// Directed bench for bnn_input_loader: timing, gaps, all-ones, abort,
// ignored bytes outside the load window, and asynchronous reset.
module tb_bnn_input_loader;
    localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_L1 = 3'd2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bnn_input_loader_if bif ();
    bnn_input_loader dut (.clk(clk), .rst(rst), .bus(bif));

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] w1   [9] = '{8'hB1, 8'h5E, 8'hB1, 8'hD5, 8'h2A, 8'hD5, 8'hB1, 8'h5E, 8'hB1};
    logic [7:0] strm [107];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: pixel is 1 iff column even (0x55 stream); mode 1: all ones
    function automatic int pix_err(input int mode);
        int e = 0;
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++)
                if (bif.pixels[r][c] !== ((mode == 1) ? 1'b1 : ((c % 2) == 0)))
                    e++;
        return e;
    endfunction

    task automatic set_stream(input bit ones);
        for (int k = 0; k < 9; k++)   strm[k] = ones ? 8'hFF : w1[k];
        for (int k = 9; k < 107; k++) strm[k] = ones ? 8'hFF : 8'h55;
    endtask

    task automatic go_idle();
        @(negedge clk);
        bif.state = S_IDLE;
        bif.data_valid = 1'b0;
        @(posedge clk);
    endtask

    // Apply s_LOAD and push n bytes; cyc counts edges from the first
    // edge that sees s_LOAD through the edge of the last accept.
    task automatic run_load(input int n, input bit gap, output int cyc,
                            output int gap_bad, output int early);
        cyc = 0; gap_bad = 0; early = 0;
        @(negedge clk);
        bif.state = S_LOAD;
        bif.data_valid = 1'b0;
        @(posedge clk); cyc++;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (bif.load_done) early++;
            bif.data_valid = 1'b1;
            bif.data_in = strm[k];
            @(posedge clk); cyc++;
            if (gap && k != n - 1) begin
                @(negedge clk);
                bif.data_valid = 1'b0;
                if (bif.ready !== 1'b1) gap_bad++;
                @(posedge clk); cyc++;
            end
        end
        @(negedge clk);
        bif.data_valid = 1'b0;
    endtask

    task automatic check_t1(input string p);
        chk({p, "_done"}, bif.load_done, 1);
        chk({p, "_w11"}, bif.weights[1][1], 8'h2A);
        chk({p, "_w00"}, bif.weights[0][0], 8'hB1);
        chk({p, "_w21"}, bif.weights[2][1], 8'h5E);
        chk({p, "_pix"}, pix_err(0), 0);
        chk({p, "_csum"}, bif.checksum, 8'h2A);
    endtask

    int cyc, gb, ea;

    initial begin
        rst = 1'b1;
        bif.state = S_IDLE;
        bif.data_valid = 1'b0;
        bif.data_in = '0;
        #12;
        chk("rst_pix", $countones(bif.pixels), 0);
        chk("rst_wgt", $countones(bif.weights), 0);
        chk("rst_done", bif.load_done, 0);
        chk("rst_ready", bif.ready, 0);
        chk("rst_csum", bif.checksum, 0);
        @(negedge clk);
        rst = 1'b0;

        // 1: back-to-back load
        set_stream(0);
        run_load(107, 0, cyc, gb, ea);
        chk("t1_cycles", cyc, 108);
        chk("t1_early", ea, 0);
        check_t1("t1");

        // 2: data_valid on alternate cycles
        go_idle();
        run_load(107, 1, cyc, gb, ea);
        chk("t2_cycles", cyc, 214);
        chk("t2_gap_ready", gb, 0);
        chk("t2_early", ea, 0);
        check_t1("t2");

        // 3: all ones, then hand off to layer 1
        go_idle();
        set_stream(1);
        run_load(107, 0, cyc, gb, ea);
        chk("t3_done", bif.load_done, 1);
        chk("t3_pix", pix_err(1), 0);
        chk("t3_wgt", $countones(bif.weights), 72);
        chk("t3_csum", bif.checksum, 8'hFF);
        bif.state = S_L1;
        @(posedge clk);
        @(negedge clk);
        chk("t3_l1_done", bif.load_done, 0);
        chk("t3_l1_pix", pix_err(1), 0);
        chk("t3_l1_wgt", $countones(bif.weights), 72);

        // 4: abort while pixel byte 40 is presented
        set_stream(0);
        run_load(49, 0, cyc, gb, ea);
        bif.state = S_IDLE;
        bif.data_valid = 1'b1;
        bif.data_in = 8'h55;
        @(posedge clk);
        @(negedge clk);
        bif.data_valid = 1'b0;
        chk("t4_b40_kept", bif.pixels[11][13], 1);
        chk("t4_b39_new", bif.pixels[11][11], 0);
        chk("t4_done", bif.load_done, 0);
        chk("t4_ready", bif.ready, 0);
        chk("t4_csum", bif.checksum, 8'h2A);
        run_load(107, 0, cyc, gb, ea);
        chk("t4_cycles", cyc, 108);
        check_t1("t4");

        // 5: bytes offered in L_DONE and in s_IDLE are ignored
        bif.data_valid = 1'b1;
        bif.data_in = 8'hAA;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_t1("t5_done_state");
        bif.state = S_IDLE;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bif.data_valid = 1'b0;
        chk("t5_idle_csum", bif.checksum, 8'h2A);
        chk("t5_idle_pix", pix_err(0), 0);
        chk("t5_idle_w11", bif.weights[1][1], 8'h2A);
        chk("t5_idle_done", bif.load_done, 0);
        chk("t5_idle_ready", bif.ready, 0);

        // 6: asynchronous reset mid-load
        set_stream(1);
        run_load(59, 0, cyc, gb, ea);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_pix", $countones(bif.pixels), 0);
        chk("t6_wgt", $countones(bif.weights), 0);
        chk("t6_csum", bif.checksum, 0);
        chk("t6_done", bif.load_done, 0);
        chk("t6_ready", bif.ready, 0);
        @(negedge clk);
        bif.state = S_IDLE;
        rst = 1'b0;
        set_stream(0);
        run_load(107, 0, cyc, gb, ea);
        chk("t6_cycles", cyc, 108);
        check_t1("t6");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
